// File: rtl/jk_seq_driver.sv
// jk_seq_driver: plays a WIDTH-bit Q target sequence (LSB first) into an external JK flip-flop.
// Optional JK_FB_CHECK_EN: compares q_fb against the internal Q model and raises a sticky err.
module jk_seq_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pattern,
    input  logic             tog_pref,
    input  logic             q_fb,
    output logic             j,
    output logic             k,
    output logic             done,
    output logic             err,
    output logic             state_dbg
);

    // Handshake: a pattern transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, so in_valid is ignored while driving.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_m_q, q_m_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic             tog_q, tog_d;
    logic             done_q, done_d;
    logic             accept;
    logic             tgt;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign tgt       = pattern_q[cnt_q];
    assign done      = done_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_m_d     = q_m_q;
        pattern_d = pattern_q;
        tog_d     = tog_q;
        done_d    = 1'b0;
        j         = 1'b0;
        k         = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pattern_d = in_pattern;
                    tog_d     = tog_pref;
                    cnt_d     = '0;
                    q_m_d     = q_fb;
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                // Either set/reset excitation or toggle, chosen at accept time.
                if (tgt != q_m_q) begin
                    if (tgt) begin
                        j = 1'b1;
                        k = tog_q;
                    end else begin
                        j = tog_q;
                        k = 1'b1;
                    end
                end
                q_m_d = tgt;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            q_m_q     <= 1'b0;
            pattern_q <= '0;
            tog_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_m_q     <= q_m_d;
            pattern_q <= pattern_d;
            tog_q     <= tog_d;
            done_q    <= done_d;
        end
    end

`ifdef JK_FB_CHECK_EN
    logic err_q, err_d;

    // The done cycle is checked too, since it shows Q after the final edge.
    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if (((state_q == DRIVE) || done_q) && (q_fb != q_m_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: directed transfers against a JK flop model, scoreboarded j/k and done.
module tb_jk_seq_driver;
  localparam int W = 8;
`ifdef JK_FB_CHECK_EN
  localparam bit FB_EN = 1'b1;
`else
  localparam bit FB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_pattern = '0;
  logic tog_pref = 1'b0;
  logic q_fb = 1'b0;
  logic in_ready, j, k, done, err, state_dbg;
  logic force_fb = 1'b0;
  logic mon_en = 1'b0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] exp_q[$];
  int done_exp_q[$];

  jk_seq_driver #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pattern(in_pattern), .tog_pref(tog_pref), .q_fb(q_fb),
    .j(j), .k(k), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external JK flip-flop; force_fb pins Q low
  always @(posedge clk) begin
    if (force_fb) q_fb <= 1'b0;
    else begin
      case ({j, k})
        2'b10: q_fb <= 1'b1;
        2'b01: q_fb <= 1'b0;
        2'b11: q_fb <= ~q_fb;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every drive cycle pops one j/k, every done pulse pops one cycle stamp
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_ready !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL jk_unexpected: got drive cycle jk=%b expected idle (cyc %0d)", {j, k}, cyc);
        end else begin
          check("jk", {30'd0, j, k}, {30'd0, exp_q.pop_front()});
        end
      end
      if (done !== 1'b0) begin
        if (done_exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL done_unexpected: got done=%b expected 0 (cyc %0d)", done, cyc);
        end else begin
          check("done_cycle", cyc, done_exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drive a pattern and push its hand-computed j/k vector (MSB pair = first drive cycle)
  task automatic issue(input logic [W-1:0] pat, input logic tg, input logic [15:0] vec,
                       input int n, input bit exp_done);
    in_valid = 1'b1;
    in_pattern = pat;
    tog_pref = tg;
    for (int i = 0; i < n; i++) exp_q.push_back(vec[15-2*i -: 2]);
    if (exp_done) done_exp_q.push_back(cyc + 9);
  endtask

  initial begin
    int base;
    step(2);
    rst_n = 1'b1;
    mon_en = 1'b1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_jk", {30'd0, j, k}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_state", {31'd0, state_dbg}, 32'd0);

    // basic set/reset excitation from Q=0
    issue(8'hA6, 1'b0, 16'b00_10_00_01_00_10_01_10, 8, 1'b1);
    step(1); in_valid = 1'b0;
    step(9);
    // all-zero pattern from Q=1: one reset then holds
    issue(8'h00, 1'b0, 16'b01_00_00_00_00_00_00_00, 8, 1'b1);
    step(1); in_valid = 1'b0;
    step(9);
    // toggle excitation from Q=0
    issue(8'hA6, 1'b1, 16'b00_11_00_11_00_11_11_11, 8, 1'b1);
    step(1); in_valid = 1'b0;
    step(9);

    // back-to-back: in_valid held, second pattern accepted in the done cycle
    base = cyc;
    issue(8'hA6, 1'b0, 16'b01_10_00_01_00_10_01_10, 8, 1'b1);
    step(1);
    in_pattern = 8'hFF;
    for (int i = 0; i < 8; i++) exp_q.push_back(2'b00);
    done_exp_q.push_back(base + 18);
    for (int i = 1; i <= 8; i++) begin
      check("b2b_busy", {31'd0, in_ready}, 32'd0);
      if (i < 8) step(1);
    end
    step(1);
    check("b2b_ready_in_done", {31'd0, in_ready}, 32'd1);
    step(1);
    check("b2b_second_started", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    step(9);

    // reset during drive cycle 4 aborts with no done
    issue(8'h00, 1'b0, 16'b01_00_00_00_00_00_00_00, 4, 1'b0);
    step(1); in_valid = 1'b0;
    step(3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_jk", {30'd0, j, k}, 32'd0);
    check("abort_state", {31'd0, state_dbg}, 32'd0);
    step(12);

    // feedback stuck at 0 while driving all ones
    force_fb = 1'b1;
    issue(8'hFF, 1'b0, 16'b10_00_00_00_00_00_00_00, 8, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      step(1);
      in_valid = 1'b0;
      check("fb_err", {31'd0, err}, {31'd0, FB_EN && (c >= 3)});
    end
    force_fb = 1'b0;
    check("fb_err_before_accept", {31'd0, err}, {31'd0, FB_EN});
    issue(8'h00, 1'b0, 16'b00_00_00_00_00_00_00_00, 8, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      step(1);
      in_valid = 1'b0;
      check("fb_err_cleared", {31'd0, err}, 32'd0);
    end

    step(3);
    check("jk_queue_drained", exp_q.size(), 32'd0);
    check("done_queue_drained", done_exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
